// File: rtl/i4001_rom.sv
// i4001 program store: 2**ADDR_W x DATA_W words in banks of 2**COL_W columns, one op per clock.
// Optional build macro ROM_WRITE_LOCK_EN freezes the contents after the first read until reset.
module i4001_rom #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int COL_W  = 7,
    localparam int BANK_W = ADDR_W - COL_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] column_id,
    input  logic [BANK_W-1:0] read_id,
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] out
);

    typedef enum logic [1:0] {
        MODE_WRITE = 2'b00,
        MODE_READ  = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_IDLE  = 2'b11
    } mode_e;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_allowed;
    logic              bank_hit;

    assign bank_hit = (column_id[ADDR_W-1:COL_W] == read_id);

`ifdef ROM_WRITE_LOCK_EN
    logic lock_q;
    logic lock_d;

    // Once anything has been read back the store behaves like a mask ROM.
    always_comb begin
        lock_d = lock_q;
        if (mode == MODE_READ) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign wr_allowed = !lock_q;
`else
    assign wr_allowed = 1'b1;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        out_d     = out_q;
        case (mode)
            MODE_WRITE: begin
                mem_we    = wr_allowed;
                mem_wdata = in;
            end
            MODE_READ: begin
                out_d = bank_hit ? mem_q[column_id] : '0;
            end
            MODE_CLEAR: begin
                mem_we    = wr_allowed;
                mem_wdata = '0;
            end
            default: begin
                out_d = out_q;
            end
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive RST_N.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[column_id] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_i4001_rom.sv
// Directed bench for i4001_rom: full program/read-back, vector table, reset and turnaround sequences.
module tb_i4001_rom;

  logic        CLK;
  logic        RST_N;
  logic [10:0] column_id;
  logic [3:0]  read_id;
  logic [15:0] in;
  logic [1:0]  mode;
  logic [15:0] out;

  int vec_count;
  int miscompares;

`ifdef ROM_WRITE_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  mode;
    logic [10:0] col;
    logic [3:0]  rid;
    logic [15:0] din;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  i4001_rom dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .column_id (column_id),
    .read_id   (read_id),
    .in        (in),
    .mode      (mode),
    .out       (out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one operation, let it take effect on the next rising edge, sample 1ns later.
  task automatic op(input logic [1:0] m, input logic [10:0] col, input logic [3:0] rid,
                    input logic [15:0] din);
    mode      = m;
    column_id = col;
    read_id   = rid;
    in        = din;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    mode        = 2'b11;
    column_id   = '0;
    read_id     = '0;
    in          = '0;
    RST_N       = 1'b1;

    #1 RST_N = 1'b0;
    #1 check("reset_async", out, 16'h0000);
    repeat (2) @(posedge CLK);
    #1 check("reset_held", out, 16'h0000);
    @(negedge CLK) RST_N = 1'b1;

    // program every word with its own address; out must stay at its reset value
    for (int a = 0; a < 2048; a++) begin
      op(2'b00, a[10:0], 4'd0, 16'(a));
      check($sformatf("write_phase_out[%0d]", a), out, 16'h0000);
    end
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] addr;
      addr = a[10:0];
      op(2'b01, addr, addr[10:7], 16'h0);
      check($sformatf("readback[%0d]", a), out, 16'(a));
    end

    vecs[0] = '{2'b01, 11'h085, 4'd2,  16'h0, 16'h0000};
    vecs[1] = '{2'b01, 11'h085, 4'd1,  16'h0, 16'h0085};
    vecs[2] = '{2'b10, 11'h100, 4'd0,  16'h0, 16'h0085};
    vecs[3] = '{2'b01, 11'h100, 4'd2,  16'h0, LOCK_EN ? 16'h0100 : 16'h0000};
    vecs[4] = '{2'b01, 11'h101, 4'd2,  16'h0, 16'h0101};
    vecs[5] = '{2'b11, 11'h7FF, 4'd15, 16'hAAAA, 16'h0101};
    vecs[6] = '{2'b11, 11'h000, 4'd0,  16'h5555, 16'h0101};
    vecs[7] = '{2'b01, 11'h7FF, 4'd15, 16'h0, 16'h07FF};
    vecs[8] = '{2'b01, 11'h7FF, 4'd0,  16'h0, 16'h0000};
    vecs[9] = '{2'b01, 11'h7FF, 4'd15, 16'h0, 16'h07FF};
    for (int i = 0; i < 10; i++) begin
      op(vecs[i].mode, vecs[i].col, vecs[i].rid, vecs[i].din);
      check($sformatf("vec[%0d]", i), out, vecs[i].exp_out);
    end

    // reset asserted between edges clears out without a clock
    mode = 2'b11;
    #2 RST_N = 1'b0;
    #1 check("reset_mid_read", out, 16'h0000);
    @(posedge CLK);
    #1 check("reset_mid_held", out, 16'h0000);
    @(negedge CLK) RST_N = 1'b1;

    // write-then-read turnaround, then confirm memory survived the reset
    op(2'b00, 11'd5, 4'd0, 16'hBEEF);
    check("turn_write_out_hold", out, 16'h0000);
    op(2'b01, 11'd5, 4'd0, 16'h0);
    check("turn_read", out, 16'hBEEF);
    op(2'b01, 11'h7FF, 4'd15, 16'h0);
    check("retained_7ff", out, 16'h07FF);

    // after a read, a write is refused only when the lock is built in
    op(2'b00, 11'd5, 4'd0, 16'h1234);
    op(2'b01, 11'd5, 4'd0, 16'h0);
    check("post_read_write", out, LOCK_EN ? 16'hBEEF : 16'h1234);

    @(negedge CLK) RST_N = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    op(2'b00, 11'd5, 4'd0, 16'h1234);
    op(2'b01, 11'd5, 4'd0, 16'h0);
    check("write_after_reset", out, 16'h1234);
    op(2'b10, 11'd5, 4'd0, 16'h0);
    op(2'b01, 11'd5, 4'd0, 16'h0);
    check("clear_after_read", out, LOCK_EN ? 16'h1234 : 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/i4001_rom.md
Name: i4001_rom

Overview:
- 2048 x 16-bit program store for the i4001 project, organised as 16 banks of 128 columns.
- The host first programs it word-by-word, then reads it back through a bank-select check.
- Sits between the program loader/testbench and the instruction-fetch path; one read or write per clock.

Parameters:
- ADDR_W, 11, address width of column_id; depth = 2**ADDR_W words.
- DATA_W, 16, word width of in/out.
- COL_W, 7, column-within-bank width. Bank field = column_id[ADDR_W-1:COL_W]. BANK_W = ADDR_W-COL_W (4 at defaults).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- column_id  input  ADDR_W  word address; upper BANK_W bits = bank, lower COL_W bits = column.
- read_id  input  BANK_W  bank selected for reading.
- in  input  DATA_W  write data.
- mode  input  2  00=write, 01=read, 10=clear word, 11=idle.
- out  output  DATA_W  registered read data.

Behaviour:
- Storage: DATA_W x 2**ADDR_W array. Contents are not affected by reset and are undefined until written.
- Reset (RST_N low), asynchronous: out=0 immediately and held at 0 while RST_N is low. With the optional feature compiled in, lock=0. Normal operation resumes on the first rising edge after RST_N goes high.
- mode 00 (write): on the rising edge, mem[column_id] <= in. out holds its previous value.
- mode 01 (read): on the rising edge:
  - if column_id[ADDR_W-1:COL_W] == read_id, out <= mem[column_id];
  - otherwise out <= 0 (bank not selected).
  - Latency is 1 clock: address/read_id sampled at edge N, data visible after edge N.
- mode 10 (clear): on the rising edge, mem[column_id] <= 0. out holds.
- mode 11 (idle): no memory change; out holds.
- Mode switching:
  - Mode changes take effect on the same edge they are sampled.
  - Write followed immediately by read of the same address returns the newly written data, because the write completed on the prior edge.
  - No same-edge read/write collision exists, since each edge performs only one operation.
- Address wrap: column_id is used modulo 2**ADDR_W, with no out-of-range condition. Incrementing from 2047 wraps to 0 in the driving logic; the block needs no special handling.
- out changes only on a rising edge or on asynchronous reset assertion. There is no combinational path from inputs to out.

Optional Feature:
- Macro: ROM_WRITE_LOCK_EN.
- Defined:
  - Add a 1-bit lock register, cleared by RST_N.
  - lock is set on the first edge with mode==01.
  - While lock=1, modes 00 and 10 are ignored (memory unchanged, out holds). Reads behave normally.
  - Only RST_N clears lock, emulating a mask ROM after programming.
- Not defined: no lock register; writes and clears are accepted in any cycle.

Test Plan:
- Program all: mode=00, for a=0..2047 drive column_id=a, in=a, one per clock; then mode=01, read_id=a[10:7] for each a -> out==a one clock after each address; out stays 0 during the write phase after reset.
- Bank mismatch: after programming, mode=01, column_id=0x085 (bank 1), read_id=2 -> out==0; then read_id=1 -> out==0x0085.
- Clear and idle: mode=10 at column_id=0x100 -> later read (read_id=2) gives 0. mode=11 with varying column_id -> out unchanged.
- Reset mid-read: while out==0x07FF, assert RST_N=0 between edges -> out==0 immediately without a clock edge; release and re-read 0x7FF (read_id=15) -> out==0x07FF (memory retained).
- Write-then-read turnaround: edge1 mode=00, addr 5, in=0xBEEF; edge2 mode=01, addr 5, read_id=0 -> out==0xBEEF after edge2.
- With ROM_WRITE_LOCK_EN: after any read, mode=00 addr 5, in=0x1234 -> re-read still 0xBEEF; after RST_N pulse the write succeeds. Without the macro, the same sequence reads 0x1234.
